mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- CPU-side initiator for the multicycle core's unified single-port instruction/data memory.
- Accepts one fetch, load or store request at a time from the control unit over a valid/ready handshake.
- Drives the memory's `we`, `writedata`, `pc`, `dataaddr`, `iord` and `irwrite` inputs, and absorbs the memory's one-cycle registered read latency.
- Returns the result on a one-cycle response pulse; rejects misaligned or out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, 512, size of the memory in bytes (128 words); any access with addr >= MEM_BYTES is an error.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a transfer occurs when req_valid & req_ready at a rising edge.
- req_op  in  2  operation: 00 fetch, 01 load, 10 store, 11 reserved (error).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  32  instruction (fetch), load data (load), or 0 (store/error).
- resp_err  out  1  qualifies resp_valid; the access was rejected.
- mem_we  out  1  memory write enable.
- mem_writedata  out  32  memory write data.
- mem_pc  out  32  memory instruction address.
- mem_dataaddr  out  32  memory data address.
- mem_iord  out  1  selects the data address (1) or pc (0).
- mem_irwrite  out  1  memory instruction-register load enable.
- mem_instr  in  32  memory's registered instruction output.
- mem_readdata  in  32  memory's registered data output.
- fetch_count  out  32  completed fetches; wraps modulo 2^32.
- err_count  out  ERR_CNT_W  rejected requests; saturates at all-ones.

Behaviour:
- States: IDLE, ACCESS, CAPTURE.
- Reset: state=IDLE. The following are all 0: resp_valid, resp_err, resp_data, fetch_count, err_count, and the internal op/addr/wdata registers.
- Reset takes priority over every other event, including mid-operation. An in-flight request is dropped and no response is issued.
- mem_we is gated combinationally by !reset, so no write occurs in a cycle where reset is high.
- IDLE:
  - req_ready=1.
  - On handshake, register op/addr/wdata.
  - Error condition: req_op==11, or req_addr[1:0]!=0, or req_addr>=MEM_BYTES.
  - On error: stay in IDLE; next cycle resp_valid=1, resp_err=1, resp_data=0; err_count increments (saturating). No memory signal asserts.
  - Otherwise: go to ACCESS.
- ACCESS (1 cycle):
  - Fetch: mem_iord=0, mem_pc=addr, mem_irwrite=1 → CAPTURE.
  - Load: mem_iord=1, mem_dataaddr=addr → CAPTURE.
  - Store: mem_iord=1, mem_dataaddr=addr, mem_writedata=wdata, mem_we=1 → IDLE. Next cycle resp_valid=1, resp_err=0, resp_data=0.
- CAPTURE (1 cycle):
  - Memory output is valid this cycle.
  - Fetch: mem_irwrite=0 and mem_pc held, so the memory's instruction register holds.
  - Load: mem_iord=1 and mem_dataaddr held, so the memory's data register stays stable.
  - At the ending edge: resp_data <= mem_instr (fetch) or mem_readdata (load); resp_valid <= 1, resp_err <= 0.
  - Fetch only: fetch_count increments.
  - → IDLE.
- Latency, with the handshake in cycle 0:
  - fetch/load: resp_valid in cycle 3.
  - store: resp_valid in cycle 2.
  - error: resp_valid in cycle 1.
- Throughput:
  - resp_valid coincides with IDLE, so a new request is accepted in the same cycle as a response.
  - Back-to-back loads complete every 3 cycles.
- resp_valid is a single-cycle pulse. resp_data holds its value until the next response.
- Outside ACCESS/CAPTURE: mem_we=0, mem_irwrite=0, mem_iord=0, mem_pc=0, mem_dataaddr=0, mem_writedata=0.
- req_* inputs are ignored when req_ready=0.
- No request is ever in flight while another is pending.

Test Plan:
- Reset, then fetch at addr 0x0 with memory word0=0x20080005 → mem_irwrite=1 in cycle 1 only; resp_valid in cycle 3 with resp_data=0x20080005; fetch_count=1.
- Store 0xDEADBEEF to 0x40, then load 0x40 → store: mem_we high exactly one cycle, resp_valid in cycle 2 with resp_data=0. Load: resp_data=0xDEADBEEF three cycles after its handshake, resp_err=0.
- Load from 0x41, load from 0x200, and req_op=11 → each gives resp_valid with resp_err=1 one cycle after handshake; mem_we and mem_irwrite stay 0; err_count=3.
- Hold req_valid high with four back-to-back loads of 0x0, 0x4, 0x8, 0xC → one accepted every 3 cycles; req_ready low in ACCESS/CAPTURE; responses in order with the correct words.
- Assert reset during ACCESS of a store → no memory write occurs (the word reads back unchanged); no resp_valid; state returns to IDLE with req_ready=1 the cycle after reset drops.
- Force 256 errors → err_count saturates at 255 and does not wrap.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Request/response initiator for the multicycle core's unified single-port memory.
// Sequences fetch/load/store accesses and absorbs the memory's one-cycle registered read latency.
module mem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 512,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  output logic                 mem_we,
  output logic [31:0]          mem_writedata,
  output logic [31:0]          mem_pc,
  output logic [31:0]          mem_dataaddr,
  output logic                 mem_iord,
  output logic                 mem_irwrite,
  input  logic [31:0]          mem_instr,
  input  logic [31:0]          mem_readdata,
  output logic [31:0]          fetch_count,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {StIdle, StAccess, StCapture} state_e;

  localparam logic [1:0] OpFetch = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   resp_valid_q, resp_valid_d;
  logic                   resp_err_q, resp_err_d;
  logic [31:0]            resp_data_q, resp_data_d;
  logic [31:0]            fetch_count_q, fetch_count_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
  logic                   mem_we_raw;
  logic                   req_fire;
  logic                   req_bad;

  assign req_fire = req_valid & req_ready;
  assign req_bad  = (req_op == 2'b11) || (req_addr[1:0] != 2'b00) ||
                    (req_addr >= 32'(MEM_BYTES));

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_data_d   = resp_data_q;
    fetch_count_d = fetch_count_q;
    err_count_d   = err_count_q;
    req_ready     = 1'b0;
    mem_we_raw    = 1'b0;
    mem_writedata = 32'h0;
    mem_pc        = 32'h0;
    mem_dataaddr  = 32'h0;
    mem_iord      = 1'b0;
    mem_irwrite   = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_fire) begin
          op_d    = req_op;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_bad) begin
            // Rejected without leaving IDLE; memory never sees the access.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = 32'h0;
            if (err_count_q != {ERR_CNT_W{1'b1}}) begin
              err_count_d = err_count_q + ERR_CNT_W'(1);
            end
          end else begin
            state_d = StAccess;
          end
        end
      end

      StAccess: begin
        unique case (op_q)
          OpFetch: begin
            mem_pc      = addr_q;
            mem_irwrite = 1'b1;
            state_d     = StCapture;
          end
          OpLoad: begin
            mem_iord     = 1'b1;
            mem_dataaddr = addr_q;
            state_d      = StCapture;
          end
          OpStore: begin
            mem_iord      = 1'b1;
            mem_dataaddr  = addr_q;
            mem_writedata = wdata_q;
            mem_we_raw    = 1'b1;
            resp_valid_d  = 1'b1;
            resp_data_d   = 32'h0;
            state_d       = StIdle;
          end
          default: state_d = StIdle;
        endcase
      end

      StCapture: begin
        // Address held and irwrite dropped so the memory's output registers stay put.
        if (op_q == OpFetch) begin
          mem_pc        = addr_q;
          resp_data_d   = mem_instr;
          fetch_count_d = fetch_count_q + 32'd1;
        end else begin
          mem_iord     = 1'b1;
          mem_dataaddr = addr_q;
          resp_data_d  = mem_readdata;
        end
        resp_valid_d = 1'b1;
        state_d      = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  // A write must never land in a cycle where reset is asserted.
  assign mem_we = mem_we_raw & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      op_q          <= 2'b00;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_data_q   <= 32'h0;
      fetch_count_q <= 32'h0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_data_q   <= resp_data_d;
      fetch_count_q <= fetch_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_data   = resp_data_q;
  assign fetch_count = fetch_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural single-port memory
// (registered instruction and data outputs) attached to the memory-side ports.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_writedata;
  logic [31:0] mem_pc;
  logic [31:0] mem_dataaddr;
  logic        mem_iord;
  logic        mem_irwrite;
  logic [31:0] mem_instr;
  logic [31:0] mem_readdata;
  logic [31:0] fetch_count;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .MEM_BYTES(512),
    .ERR_CNT_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_err     (resp_err),
    .mem_we       (mem_we),
    .mem_writedata(mem_writedata),
    .mem_pc       (mem_pc),
    .mem_dataaddr (mem_dataaddr),
    .mem_iord     (mem_iord),
    .mem_irwrite  (mem_irwrite),
    .mem_instr    (mem_instr),
    .mem_readdata (mem_readdata),
    .fetch_count  (fetch_count),
    .err_count    (err_count)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h2008_0005;
      1:       return 32'h1111_1111;
      2:       return 32'h2222_2222;
      3:       return 32'h3333_3333;
      32:      return 32'hCAFE_F00D;
      127:     return 32'h7F7F_0001;
      default: return 32'h1000_0000 | 32'(i);
    endcase
  endfunction

  // Memory model: write on we, instruction register on irwrite, data register every cycle.
  logic [31:0] mem [128];
  logic        mem_init_done = 1'b0;
  logic [31:0] rd_addr;
  assign rd_addr = mem_iord ? mem_dataaddr : mem_pc;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else begin
      if (mem_we) mem[mem_dataaddr[8:2]] <= mem_writedata;
      if (mem_irwrite) mem_instr <= mem[mem_pc[8:2]];
      mem_readdata <= mem[rd_addr[8:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues one request at a negedge and watches 8 cycles (cycle 0 = handshake cycle).
  task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic err, output logic [31:0] data,
                        output int we_cnt, output int irw_cnt, output int irw_first);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    lat = -1; err = 1'b0; data = 32'h0; we_cnt = 0; irw_cnt = 0; irw_first = -1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0 && resp_valid && lat < 0) begin
        lat  = c;
        err  = resp_err;
        data = resp_data;
      end
      if (mem_we) we_cnt++;
      if (mem_irwrite) begin
        irw_cnt++;
        if (irw_first < 0) irw_first = c;
      end
      @(negedge clk);
      if (c == 0) req_valid = 1'b0;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int          lat, we_cnt, irw_cnt, irw_first;
    logic        err;
    logic [31:0] data;
    int          exp_fetch;
    int          exp_errc;
    int          acc[4];
    int          idx, rsp, stray;

    vecs[0]  = '{2'b00, 32'h0000_0000, 32'h0,           1'b0, 32'h2008_0005, 3};
    vecs[1]  = '{2'b10, 32'h0000_0040, 32'hDEAD_BEEF,   1'b0, 32'h0,         2};
    vecs[2]  = '{2'b01, 32'h0000_0040, 32'h0,           1'b0, 32'hDEAD_BEEF, 3};
    vecs[3]  = '{2'b01, 32'h0000_0041, 32'h0,           1'b1, 32'h0,         1};
    vecs[4]  = '{2'b01, 32'h0000_0200, 32'h0,           1'b1, 32'h0,         1};
    vecs[5]  = '{2'b11, 32'h0000_0000, 32'h0,           1'b1, 32'h0,         1};
    vecs[6]  = '{2'b01, 32'h0000_01FC, 32'h0,           1'b0, 32'h7F7F_0001, 3};
    vecs[7]  = '{2'b10, 32'h0000_01FC, 32'h55AA_55AA,   1'b0, 32'h0,         2};
    vecs[8]  = '{2'b01, 32'h0000_01FC, 32'h0,           1'b0, 32'h55AA_55AA, 3};
    vecs[9]  = '{2'b00, 32'h0000_0004, 32'h0,           1'b0, 32'h1111_1111, 3};
    vecs[10] = '{2'b00, 32'h0000_0202, 32'h0,           1'b1, 32'h0,         1};
    vecs[11] = '{2'b10, 32'h0000_01FE, 32'h0BAD_0BAD,   1'b1, 32'h0,         1};
    vecs[12] = '{2'b00, 32'h0000_01FC, 32'h0,           1'b0, 32'h55AA_55AA, 3};
    vecs[13] = '{2'b01, 32'h0000_0044, 32'h0,           1'b0, 32'h1000_0011, 3};

    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_req_ready",   32'(req_ready),   32'd1);
    chk("rst_resp_valid",  32'(resp_valid),  32'd0);
    chk("rst_resp_err",    32'(resp_err),    32'd0);
    chk("rst_resp_data",   resp_data,        32'h0);
    chk("rst_fetch_count", fetch_count,      32'h0);
    chk("rst_err_count",   32'(err_count),   32'h0);
    chk("rst_mem_ctrl",    {28'h0, mem_we, mem_iord, mem_irwrite, 1'b0}, 32'h0);
    chk("rst_mem_addr",    mem_pc | mem_dataaddr | mem_writedata, 32'h0);

    exp_fetch = 0;
    exp_errc  = 0;
    foreach (vecs[i]) begin
      do_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, err, data, we_cnt, irw_cnt, irw_first);
      if (vecs[i].exp_err) exp_errc = (exp_errc == 255) ? 255 : exp_errc + 1;
      else if (vecs[i].op == 2'b00) exp_fetch++;
      chk($sformatf("v%0d_latency", i),   32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_resp_err", i),  32'(err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_resp_data", i), data,     vecs[i].exp_data);
      chk($sformatf("v%0d_we_cycles", i), 32'(we_cnt),
          32'(!vecs[i].exp_err && vecs[i].op == 2'b10));
      chk($sformatf("v%0d_irwrite_cycles", i), 32'(irw_cnt),
          32'(!vecs[i].exp_err && vecs[i].op == 2'b00));
      chk($sformatf("v%0d_irwrite_first", i), 32'(irw_first),
          (!vecs[i].exp_err && vecs[i].op == 2'b00) ? 32'd1 : 32'hFFFF_FFFF);
      chk($sformatf("v%0d_fetch_count", i), fetch_count, 32'(exp_fetch));
      chk($sformatf("v%0d_err_count", i),   32'(err_count), 32'(exp_errc));
    end

    // Back-to-back loads with req_valid held high.
    @(negedge clk);
    req_op = 2'b01; req_valid = 1'b1; req_addr = 32'h0;
    idx = 0; rsp = 0;
    for (int c = 0; c < 30 && rsp < 4; c++) begin
      if (resp_valid) begin
        chk($sformatf("b2b_data%0d", rsp), resp_data, init_word(rsp));
        chk($sformatf("b2b_err%0d", rsp),  32'(resp_err), 32'd0);
        chk($sformatf("b2b_resp_cycle%0d", rsp), 32'(c), 32'(acc[rsp] + 3));
        rsp++;
      end
      if (req_ready) begin
        if (idx < 4) begin
          req_addr = 32'(idx * 4);
          acc[idx] = c;
          idx++;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b_responses", 32'(rsp), 32'd4);
    for (int i = 0; i < 3; i++) chk($sformatf("b2b_spacing%0d", i), 32'(acc[i+1] - acc[i]), 32'd3);

    // Reset asserted while a store sits in ACCESS.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_addr = 32'h80; req_wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_in_access", 32'(mem_iord), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_we_gated", 32'(mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) stray++;
      @(negedge clk);
    end
    chk("rst_mid_no_resp", 32'(stray), 32'd0);
    chk("rst_mid_counts", fetch_count | 32'(err_count), 32'h0);
    do_req(2'b01, 32'h80, 32'h0, lat, err, data, we_cnt, irw_cnt, irw_first);
    chk("rst_mid_word_kept", data, 32'hCAFE_F00D);
    chk("rst_mid_load_lat", 32'(lat), 32'd3);

    // Saturation: one error accepted per cycle with req_valid held.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_addr = 32'h0;
    repeat (200) @(negedge clk);
    chk("sat_count_200", 32'(err_count), 32'd200);
    chk("sat_resp_err", 32'(resp_err & resp_valid), 32'd1);
    repeat (60) @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("sat_count_max", 32'(err_count), 32'd255);
    chk("sat_mem_quiet", {30'h0, mem_we, mem_irwrite}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
